// File: rtl/pc_redirect_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit_pkg
// Types and constants shared by the fetch PC redirect logic, the PC-select
// interface and the decode/fetch blocks that connect to it.
//   word_t            32-bit address/data word
//   pc_state_e        redirect FSM state (NORMAL, PENDING)
//   RESET_PC_DEFAULT  default fetch address after reset
//   pc_plus4()        sequential next fetch address, wraps modulo 2^32
// ---------------------------------------------------------------------------
package pc_redirect_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        NORMAL  = 1'b0,
        PENDING = 1'b1
    } pc_state_e;

    localparam word_t RESET_PC_DEFAULT = 32'hBFC0_0000;

    function automatic word_t pc_plus4(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_redirect_unit_if.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit_if
// PC-select interface between decode/fetch control and the PC redirect unit.
//   exception/pcexception     exception redirect request and vector
//   branch_taken/pcbranchD    decode-stage taken branch and target
//   jr/pcjrD                  decode-stage register jump and target
//   jump/pcjumpD              decode-stage immediate jump and target
//   stallF                    fetch hold from the hazard unit
//   addr_ok                   instruction memory accepted the request
//   req/pcF                   fetch request valid and address
//   pcplus4F                  pcF + 4
//   adelF                     fetch address misaligned
// Modports: select (the redirect unit), master (the control side).
// ---------------------------------------------------------------------------
interface pc_redirect_unit_if;
    import pc_redirect_unit_pkg::*;

    logic  exception;
    word_t pcexception;
    logic  branch_taken;
    word_t pcbranchD;
    logic  jr;
    word_t pcjrD;
    logic  jump;
    word_t pcjumpD;
    logic  stallF;
    logic  addr_ok;
    logic  req;
    word_t pcF;
    word_t pcplus4F;
    logic  adelF;

    modport select (
        input  exception, pcexception, branch_taken, pcbranchD, jr, pcjrD,
               jump, pcjumpD, stallF, addr_ok,
        output req, pcF, pcplus4F, adelF
    );

    modport master (
        output exception, pcexception, branch_taken, pcbranchD, jr, pcjrD,
               jump, pcjumpD, stallF, addr_ok,
        input  req, pcF, pcplus4F, adelF
    );

endinterface

// File: rtl/pc_next_mux.sv
// ---------------------------------------------------------------------------
// pc_next_mux
// Pure combinational next-PC priority selection:
//   exception > pending redirect > branch_taken > jr > jump > pcplus4.
// Ports:
//   exception/pcexception       exception redirect and vector
//   pending_valid/pending_target  held redirect from an earlier cycle
//   branch_taken/jr/jump + targets  decode-stage redirects
//   pcplus4                     sequential address
//   redirect                    any decode-stage redirect this cycle
//   redirect_target             highest-priority decode-stage target
//   next_pc                     address to load when the PC updates
// ---------------------------------------------------------------------------
module pc_next_mux
    import pc_redirect_unit_pkg::*;
(
    input  logic  exception,
    input  word_t pcexception,
    input  logic  pending_valid,
    input  word_t pending_target,
    input  logic  branch_taken,
    input  word_t pcbranchD,
    input  logic  jr,
    input  word_t pcjrD,
    input  logic  jump,
    input  word_t pcjumpD,
    input  word_t pcplus4,
    output logic  redirect,
    output word_t redirect_target,
    output word_t next_pc
);

    always_comb begin
        // NOTE: every output gets a default before the if-chains, so no path
        // leaves a signal unassigned and no latch is inferred.
        redirect        = branch_taken | jr | jump;
        redirect_target = pcjumpD;
        next_pc         = pcplus4;

        // Targets pass through untouched; misalignment is reported via adelF.
        if (branch_taken) begin
            redirect_target = pcbranchD;
        end else if (jr) begin
            redirect_target = pcjrD;
        end

        if (exception) begin
            next_pc = pcexception;
        end else if (pending_valid) begin
            next_pc = pending_target;
        end else if (redirect) begin
            next_pc = redirect_target;
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit
// Holds the fetch PC and decides when and where it moves. The PC only moves
// when the current request is accepted (advance) or on an exception. A
// redirect that arrives while the request cannot advance is parked in a
// pending register and applied at the next advance, so the address never
// changes in the middle of a memory handshake.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     PC-select interface, select modport
// Parameter:
//   RESET_PC  fetch address after reset
// ---------------------------------------------------------------------------
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    pc_redirect_unit_if.select  bus
);

    pc_state_e state_q, state_d;
    word_t     pc_q, pc_d;
    word_t     pending_q, pending_d;
    logic      released_q;

    logic  advance;
    logic  redirect;
    word_t redirect_target;
    word_t next_pc;

    // req waits for the first edge after reset release; a misaligned PC
    // suppresses requests until an exception moves it somewhere sane.
    assign bus.pcF      = pc_q;
    assign bus.pcplus4F = pc_plus4(pc_q);
    assign bus.adelF    = (pc_q[1:0] != 2'b00);
    assign bus.req      = released_q & ~bus.adelF;

    assign advance = bus.req & bus.addr_ok & ~bus.stallF;

    pc_next_mux u_next_mux (
        .exception       (bus.exception),
        .pcexception     (bus.pcexception),
        .pending_valid   (state_q == PENDING),
        .pending_target  (pending_q),
        .branch_taken    (bus.branch_taken),
        .pcbranchD       (bus.pcbranchD),
        .jr              (bus.jr),
        .pcjrD           (bus.pcjrD),
        .jump            (bus.jump),
        .pcjumpD         (bus.pcjumpD),
        .pcplus4         (bus.pcplus4F),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .next_pc         (next_pc)
    );

    // The mux already orders exception > pending > redirect > sequential, so
    // this block only decides whether the PC loads and what the FSM does.
    // In PENDING an advance takes the held target and ignores any new
    // redirect; without an advance a new redirect overwrites the held one.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;

        if (bus.exception) begin
            pc_d      = next_pc;
            pending_d = '0;
            state_d   = NORMAL;
        end else if (advance) begin
            pc_d    = next_pc;
            state_d = NORMAL;
        end else if (redirect) begin
            pending_d = redirect_target;
            state_d   = PENDING;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= NORMAL;
            pc_q       <= RESET_PC;
            pending_q  <= '0;
            released_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            released_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_unit
// Self-checking bench for pc_redirect_unit: directed scenarios with literal
// expectations, then randomized stimulus compared every cycle against a
// behavioural model that keeps the PC as a number and the parked redirect
// as a queue of at most one target.
// ---------------------------------------------------------------------------
module tb_pc_redirect_unit;
    import pc_redirect_unit_pkg::*;

    localparam word_t RST_PC = 32'hBFC0_0000;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    pc_redirect_unit_if bus ();

    pc_redirect_unit #(.RESET_PC(RST_PC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    word_t m_pc       = RST_PC;
    bit    m_released = 1'b0;
    word_t m_pend[$];

    function automatic bit m_req();
        return m_released && (m_pc[1:0] == 2'b00);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_pc       = RST_PC;
                m_released = 1'b0;
                m_pend.delete();
            end else begin
                bit    adv;
                bit    redir;
                word_t tgt;
                adv   = m_req() && bus.addr_ok && !bus.stallF;
                redir = bus.branch_taken || bus.jr || bus.jump;
                tgt   = bus.branch_taken ? bus.pcbranchD :
                        bus.jr           ? bus.pcjrD     : bus.pcjumpD;
                if (bus.exception) begin
                    m_pc = bus.pcexception;
                    m_pend.delete();
                end else if (m_pend.size() != 0) begin
                    if (adv)        m_pc = m_pend.pop_front();
                    else if (redir) m_pend[0] = tgt;
                end else if (redir) begin
                    if (adv) m_pc = tgt;
                    else     m_pend.push_back(tgt);
                end else if (adv) begin
                    m_pc = m_pc + 32'd4;
                end
                m_released = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("cmp_req",      word_t'(bus.req),   word_t'(m_req()));
            check("cmp_pcF",      bus.pcF,            m_pc);
            check("cmp_pcplus4F", bus.pcplus4F,       m_pc + 32'd4);
            check("cmp_adelF",    word_t'(bus.adelF), word_t'(m_pc[1:0] != 2'b00));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.exception    = 1'b0;
        bus.pcexception  = '0;
        bus.branch_taken = 1'b0;
        bus.pcbranchD    = '0;
        bus.jr           = 1'b0;
        bus.pcjrD        = '0;
        bus.jump         = 1'b0;
        bus.pcjumpD      = '0;
        bus.stallF       = 1'b0;
        bus.addr_ok      = 1'b1;
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    function automatic word_t rand_target();
        word_t t;
        t = $urandom();
        if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    initial begin
        idle();
        resetn = 1'b0;
        cyc();
        cyc();
        check("rst_pcF",      bus.pcF,             32'hBFC0_0000);
        check("rst_req",      word_t'(bus.req),    32'd0);
        check("rst_pcplus4F", bus.pcplus4F,        32'hBFC0_0004);

        // Reset release and sequential fetch.
        resetn = 1'b1;
        cyc();
        check("seq0_pcF", bus.pcF,          32'hBFC0_0000);
        check("seq0_req", word_t'(bus.req), 32'd1);
        cyc(); check("seq1_pcF", bus.pcF, 32'hBFC0_0004);
        cyc(); check("seq2_pcF", bus.pcF, 32'hBFC0_0008);
        cyc(); check("seq3_pcF", bus.pcF, 32'hBFC0_000C);

        // Branch beats jump in the same cycle.
        bus.branch_taken = 1'b1; bus.pcbranchD = 32'hBFC0_0100;
        bus.jump         = 1'b1; bus.pcjumpD   = 32'hBFC0_0500;
        cyc(); idle();
        check("prio_pcF", bus.pcF, 32'hBFC0_0100);

        // Redirect while addr_ok low: parked, then applied; the newer
        // target offered on the advancing cycle is ignored.
        bus.branch_taken = 1'b1; bus.pcbranchD = 32'hBFC0_0200; bus.addr_ok = 1'b0;
        cyc(); check("pend_hold1", bus.pcF, 32'hBFC0_0100);
        cyc(); check("pend_hold2", bus.pcF, 32'hBFC0_0100);
        check("pend_req", word_t'(bus.req), 32'd1);
        bus.pcbranchD = 32'hBFC0_0AA0; bus.addr_ok = 1'b1;
        cyc(); idle();
        check("pend_apply", bus.pcF, 32'hBFC0_0200);
        cyc(); check("pend_after", bus.pcF, 32'hBFC0_0204);

        // Exception in PENDING under stall wins and discards the target.
        bus.jump = 1'b1; bus.pcjumpD = 32'hBFC0_0600; bus.stallF = 1'b1;
        cyc(); check("exc_hold", bus.pcF, 32'hBFC0_0204);
        bus.jump = 1'b0; bus.exception = 1'b1; bus.pcexception = 32'hBFC0_0380;
        cyc(); idle();
        check("exc_pcF", bus.pcF, 32'hBFC0_0380);
        cyc(); check("exc_seq1", bus.pcF, 32'hBFC0_0384);
        cyc(); check("exc_seq2", bus.pcF, 32'hBFC0_0388);

        // Misaligned jr target: adelF set, req dropped until an exception.
        bus.jr = 1'b1; bus.pcjrD = 32'hBFC0_0402;
        cyc(); idle();
        check("adel_pcF", bus.pcF,            32'hBFC0_0402);
        check("adel_flag", word_t'(bus.adelF), 32'd1);
        check("adel_req",  word_t'(bus.req),   32'd0);
        bus.branch_taken = 1'b1; bus.pcbranchD = 32'hBFC0_0700;
        cyc(); idle();
        cyc();
        check("adel_stuck", bus.pcF, 32'hBFC0_0402);
        bus.exception = 1'b1; bus.pcexception = 32'hBFC0_0380;
        cyc(); idle();
        check("adel_exc_pcF", bus.pcF,            32'hBFC0_0380);
        check("adel_exc_req", word_t'(bus.req),   32'd1);
        check("adel_exc_flag", word_t'(bus.adelF), 32'd0);
        cyc(); check("adel_no_stale", bus.pcF, 32'hBFC0_0384);

        // pcplus4F wraps at the top of the address space.
        bus.jump = 1'b1; bus.pcjumpD = 32'hFFFF_FFFC;
        cyc(); idle();
        check("wrap_pcF",    bus.pcF,      32'hFFFF_FFFC);
        check("wrap_plus4",  bus.pcplus4F, 32'h0000_0000);
        cyc(); check("wrap_next", bus.pcF, 32'h0000_0000);

        // Reset while PENDING discards the parked target.
        bus.branch_taken = 1'b1; bus.pcbranchD = 32'h8000_1000; bus.addr_ok = 1'b0;
        cyc();
        bus.branch_taken = 1'b0;
        check("rp_hold", bus.pcF, 32'h0000_0000);
        #2 resetn = 1'b0;
        #1;
        check("rp_async_pcF", bus.pcF,          32'hBFC0_0000);
        check("rp_async_req", word_t'(bus.req), 32'd0);
        idle();
        cyc();
        resetn = 1'b1;
        cyc(); check("rp_seq0", bus.pcF, 32'hBFC0_0000);
        cyc(); check("rp_seq1", bus.pcF, 32'hBFC0_0004);
        cyc(); check("rp_seq2", bus.pcF, 32'hBFC0_0008);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.exception    = ($urandom_range(0, 19) == 0);
            bus.pcexception  = {$urandom_range(0, 65535), 16'h0000} | 32'h0000_0180;
            bus.branch_taken = ($urandom_range(0, 5) == 0);
            bus.pcbranchD    = rand_target();
            bus.jr           = ($urandom_range(0, 7) == 0);
            bus.pcjrD        = rand_target();
            bus.jump         = ($urandom_range(0, 7) == 0);
            bus.pcjumpD      = rand_target();
            bus.stallF       = ($urandom_range(0, 3) == 0);
            bus.addr_ok      = ($urandom_range(0, 9) < 7);
            resetn           = ($urandom_range(0, 399) != 0);
            cyc();
        end

        idle();
        resetn = 1'b1;
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'hBFC00000, fetch address after reset.
REQ-002 SHALL have port: clk  input  1  single clock, rising edge.
REQ-003 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: exception  input  1  exception redirect request.
REQ-005 SHALL have port: pcexception  input  32  exception vector target.
REQ-006 SHALL have port: branch_taken  input  1  decode-stage taken branch.
REQ-007 SHALL have port: pcbranchD  input  32  branch target.
REQ-008 SHALL have port: jr  input  1  decode-stage register jump.
REQ-009 SHALL have port: pcjrD  input  32  register jump target.
REQ-010 SHALL have port: jump  input  1  decode-stage immediate jump.
REQ-011 SHALL have port: pcjumpD  input  32  immediate jump target.
REQ-012 SHALL have port: stallF  input  1  fetch stage hold from hazard unit.
REQ-013 SHALL have port: addr_ok  input  1  instruction memory accepted the current request.
REQ-014 SHALL have port: req  output  1  fetch request valid to instruction memory.
REQ-015 SHALL have port: pcF  output  32  current fetch address (request address).
REQ-016 SHALL have port: pcplus4F  output  32  pcF + 4, for decode link/branch arithmetic.
REQ-017 SHALL have port: adelF  output  1  fetch address misaligned (pcF[1:0] != 0).

Function
REQ-018 SHALL define advance = req & addr_ok & ~stallF; pcF updates on a rising edge only when advance or exception.
REQ-019 SHALL compute pcplus4F combinationally as pcF + 4, modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-020 SHALL prioritise next-PC selection: exception > pending redirect > branch_taken > jr > jump > pcplus4F.
REQ-021 SHALL have states NORMAL and PENDING; PENDING holds a 32-bit pending target register.
REQ-022 NORMAL: redirect (branch_taken|jr|jump) with advance -> pcF <= selected target next edge, stay NORMAL.
REQ-023 NORMAL: redirect without advance -> latch selected target into pending register, go PENDING, pcF unchanged.
REQ-024 PENDING: on advance -> pcF <= pending target, go NORMAL; a new redirect in the same cycle is ignored.
REQ-025 PENDING: redirect without advance -> pending target overwritten by the newly selected target, stay PENDING.
REQ-026 SHALL apply exception on the next edge regardless of stallF/addr_ok: pcF <= pcexception, pending discarded, state NORMAL.
REQ-027 SHALL drive adelF = (pcF[1:0] != 2'b00) and req = resetn_released & ~adelF; pcF holds until an exception redirect.
REQ-028 SHALL keep pcF and req stable while req=1 and addr_ok=0 (no address change mid-handshake except on exception).
REQ-029 Redirect targets SHALL be taken as-is; no alignment correction.

Reset
REQ-030 On resetn=0 (asynchronous): pcF = RESET_PC, state NORMAL, pending register = 0, req = 0.
REQ-031 req SHALL assert on the first rising edge after resetn deasserts; reset mid-PENDING discards the pending target.

Structure
REQ-032 State enum (NORMAL, PENDING) and RESET_PC default SHALL live in the shared global package; word_t from that package for all 32-bit ports.
REQ-033 SHALL be connected to decode/fetch through the existing PC-select interface select modport; no sub-module required, optional pure-combinational next-PC priority mux sub-module named pc_next_mux.

Verification
REQ-034 Reset release, addr_ok=1, stallF=0 for 3 cycles -> pcF = BFC00000, BFC00004, BFC00008, BFC0000C; req=1 from cycle 1.
REQ-035 branch_taken=1, pcbranchD=BFC00100, jump=1 same cycle, advance=1 -> next pcF = BFC00100.
REQ-036 branch_taken=1, pcbranchD=BFC00200, addr_ok=0 for 2 cycles then 1 -> pcF holds, state PENDING, then pcF = BFC00200, state NORMAL.
REQ-037 In PENDING, exception=1, pcexception=BFC00380, stallF=1 -> next pcF = BFC00380, pending cleared, no later jump to old target.
REQ-038 jr=1, pcjrD=BFC00402 -> pcF = BFC00402, adelF=1, req=0 until exception=1, pcexception=BFC00380 -> pcF = BFC00380, req=1.
REQ-039 resetn pulsed low while PENDING with target 80001000 -> pcF = BFC00000 immediately, next fetches sequential from BFC00000.
